// File: rtl/fwd_select_if.sv
// Bundle between the ID stage and the forwarding/hazard controller.
// The master side (decode logic) presents the ID instruction fields, flush
// and hold. The slave side (controller) returns the EX-stage operand selects,
// the load-use stall and the stall-cycle count.
interface fwd_select_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             hold;
  logic [1:0]       fwd_sel_rs1;
  logic [1:0]       fwd_sel_rs2;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, flush, hold,
    input  fwd_sel_rs1, fwd_sel_rs2, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, flush, hold,
    output fwd_sel_rs1, fwd_sel_rs2, stall, stall_count
  );
endinterface

// File: rtl/fwd_select_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage RV32IM pipeline.
// Tracks the producers in EX (_p0) and MEM (_p1) and registers the operand
// mux selects alongside the ID/EX register. The WB slot is not kept: the
// register file is write-through, so a WB producer never needs forwarding.
// Select codes: 00 register file, 01 MEM-stage ALU result, 10 WB result.
module fwd_select_ctrl #(
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  fwd_select_if.slave bus
);

  // EX slot (p0) and MEM slot (p1) of the tracked producers
  logic             vld_p0;
  logic [4:0]       rd_p0;
  logic             rw_p0;
  logic             mr_p0;
  logic             vld_p1;
  logic [4:0]       rd_p1;
  logic             rw_p1;

  logic [1:0]       sel_rs1_p0;
  logic [1:0]       sel_rs2_p0;
  logic [CNT_W-1:0] stall_cnt;

  logic             ex_m1;
  logic             ex_m2;
  logic             mem_m1;
  logic             mem_m2;
  logic             stall;
  logic             load_real;
  logic [1:0]       sel_rs1_d;
  logic [1:0]       sel_rs2_d;

  // A producer matches a source only if it really writes a nonzero rd that
  // the consumer actually reads.
  function automatic logic producer_match(input logic       vld,
                                          input logic       rw,
                                          input logic [4:0] rd,
                                          input logic [4:0] src,
                                          input logic       uses);
    return vld && rw && (rd != 5'd0) && (rd == src) && uses;
  endfunction

  // Youngest producer wins; a load in EX cannot forward (that case stalls).
  function automatic logic [1:0] sel_code(input logic ex_m,
                                          input logic mem_m,
                                          input logic ex_load);
    if (ex_m && !ex_load) return 2'b01;
    else if (mem_m)       return 2'b10;
    else                  return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // Hazard detection and next-state selects from the ID fields and slots
  always_comb begin
    ex_m1     = producer_match(vld_p0, rw_p0, rd_p0, bus.id_rs1, bus.id_uses_rs1);
    ex_m2     = producer_match(vld_p0, rw_p0, rd_p0, bus.id_rs2, bus.id_uses_rs2);
    mem_m1    = producer_match(vld_p1, rw_p1, rd_p1, bus.id_rs1, bus.id_uses_rs1);
    mem_m2    = producer_match(vld_p1, rw_p1, rd_p1, bus.id_rs2, bus.id_uses_rs2);
    stall     = !reset && !bus.hold && bus.id_valid && vld_p0 && mr_p0 &&
                (ex_m1 || ex_m2);
    load_real = bus.id_valid && !stall && !bus.flush;
    sel_rs1_d = sel_code(ex_m1, mem_m1, mr_p0);
    sel_rs2_d = sel_code(ex_m2, mem_m2, mr_p0);
  end

  // Control state: slot valids, registered selects and the stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      sel_rs1_p0 <= 2'b00;
      sel_rs2_p0 <= 2'b00;
      stall_cnt  <= '0;
    end else if (!bus.hold) begin
      vld_p0     <= load_real;
      vld_p1     <= vld_p0;
      sel_rs1_p0 <= load_real ? sel_rs1_d : 2'b00;
      sel_rs2_p0 <= load_real ? sel_rs2_d : 2'b00;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Slot payload advances with the pipeline; bubbles carry all-zero fields
  always_ff @(posedge clk) begin
    if (!bus.hold) begin
      rd_p0 <= load_real ? bus.id_rd        : 5'd0;
      rw_p0 <= load_real ? bus.id_reg_write : 1'b0;
      mr_p0 <= load_real ? bus.id_mem_read  : 1'b0;
      rd_p1 <= rd_p0;
      rw_p1 <= rw_p0;
    end
  end

  assign bus.fwd_sel_rs1 = sel_rs1_p0;
  assign bus.fwd_sel_rs2 = sel_rs2_p0;
  assign bus.stall       = stall;
  assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed bench for fwd_select_ctrl. The driver applies one instruction per
// cycle on the falling edge and queues the hand-computed response; a monitor
// checks STALL before the next rising edge and the selects/count after it.
module tb_fwd_select_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;

  fwd_select_if #(.CNT_W(CNT_W)) bus ();

  fwd_select_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  typedef struct {
    int             tag;
    logic           stall;
    logic [1:0]     s1;
    logic [1:0]     s2;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   tag_n = 0;
  logic [CNT_W-1:0] m_cnt = '0;

  function automatic instr_t bub();
    return '0;
  endfunction

  function automatic instr_t alu(input int rd, input int rs1, input int rs2);
    return '{1'b1, 5'(rs1), 1'b1, 5'(rs2), 1'b1, 5'(rd), 1'b1, 1'b0};
  endfunction

  function automatic instr_t addi(input int rd, input int rs1);
    return '{1'b1, 5'(rs1), 1'b1, 5'd0, 1'b0, 5'(rd), 1'b1, 1'b0};
  endfunction

  function automatic instr_t lw(input int rd, input int rs1);
    return '{1'b1, 5'(rs1), 1'b1, 5'd0, 1'b0, 5'(rd), 1'b1, 1'b1};
  endfunction

  // One cycle of stimulus plus its expected stall (this cycle) and
  // selects/count (after the rising edge)
  task automatic tick(input instr_t i, input bit fl, input bit hd, input bit rs,
                      input bit est, input logic [1:0] e1, input logic [1:0] e2);
    exp_t e;
    @(negedge clk);
    bus.id_valid     = i.v;
    bus.id_rs1       = i.rs1;
    bus.id_uses_rs1  = i.u1;
    bus.id_rs2       = i.rs2;
    bus.id_uses_rs2  = i.u2;
    bus.id_rd        = i.rd;
    bus.id_reg_write = i.rw;
    bus.id_mem_read  = i.mr;
    bus.flush        = fl;
    bus.hold         = hd;
    reset            = rs;
    if (rs) m_cnt = '0;
    else if (!hd && est && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    e.tag   = tag_n;
    e.stall = est;
    e.s1    = e1;
    e.s2    = e2;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    tag_n++;
  endtask

  task automatic drain();
    repeat (3) tick(bub(), 0, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic chk(input int tag, input string name, input int act, input int want);
    if (act != want) begin
      miscompares++;
      $display("FAIL vec%0d %s: got %0d, expected %0d", tag, name, act, want);
    end
  endtask

  // Monitor: pops one expectation per cycle the driver queued
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk(e.tag, "stall", int'(bus.stall), int'(e.stall));
        @(posedge clk);
        #1;
        chk(e.tag, "sel_rs1", int'(bus.fwd_sel_rs1), int'(e.s1));
        chk(e.tag, "sel_rs2", int'(bus.fwd_sel_rs2), int'(e.s2));
        chk(e.tag, "stall_count", int'(bus.stall_count), int'(e.cnt));
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    {bus.id_valid, bus.id_rs1, bus.id_uses_rs1, bus.id_rs2, bus.id_uses_rs2,
     bus.id_rd, bus.id_reg_write, bus.id_mem_read} = '0;
    bus.flush = 1'b0;
    bus.hold  = 1'b0;

    // reset state
    tick(bub(), 0, 0, 1, 0, 2'b00, 2'b00);
    tick(bub(), 0, 0, 1, 0, 2'b00, 2'b00);

    // back-to-back ALU dependency: EX forward on rs1
    tick(alu(5, 1, 2), 0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(6, 5, 1), 0, 0, 0, 0, 2'b01, 2'b00);
    drain();

    // one apart: MEM forward on rs2; two apart: write-through, no forward
    tick(alu(5, 1, 2), 0, 0, 0, 0, 2'b00, 2'b00);
    tick(bub(),        0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(7, 2, 5), 0, 0, 0, 0, 2'b00, 2'b10);
    drain();
    tick(alu(5, 1, 2), 0, 0, 0, 0, 2'b00, 2'b00);
    tick(bub(),        0, 0, 0, 0, 2'b00, 2'b00);
    tick(bub(),        0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(7, 5, 5), 0, 0, 0, 0, 2'b00, 2'b00);
    drain();

    // two producers of x5: youngest wins on both operands
    tick(alu(5, 1, 2), 0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(5, 3, 4), 0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(8, 5, 5), 0, 0, 0, 0, 2'b01, 2'b01);
    drain();

    // load-use: one stall with bubble, then WB-path select
    tick(lw(5, 1),     0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(6, 5, 5), 0, 0, 0, 1, 2'b00, 2'b00);
    tick(alu(6, 5, 5), 0, 0, 0, 0, 2'b10, 2'b10);
    drain();

    // x0 is never forwarded or stalled on
    tick(addi(0, 0),   0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(1, 0, 0), 0, 0, 0, 0, 2'b00, 2'b00);
    drain();
    tick(lw(0, 1),     0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(1, 0, 0), 0, 0, 0, 0, 2'b00, 2'b00);
    drain();

    // load followed by an unrelated consumer
    tick(lw(3, 1),     0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(4, 1, 2), 0, 0, 0, 0, 2'b00, 2'b00);
    drain();

    // hold freezes everything (flush during hold ignored), then one stall
    tick(alu(1, 2, 3), 0, 0, 0, 0, 2'b00, 2'b00);
    tick(lw(5, 1),     0, 0, 0, 0, 2'b01, 2'b00);
    tick(alu(6, 5, 2), 0, 1, 0, 0, 2'b01, 2'b00);
    tick(alu(6, 5, 2), 1, 1, 0, 0, 2'b01, 2'b00);
    tick(alu(6, 5, 2), 0, 1, 0, 0, 2'b01, 2'b00);
    tick(alu(6, 5, 2), 0, 0, 0, 1, 2'b00, 2'b00);
    tick(alu(6, 5, 2), 0, 0, 0, 0, 2'b10, 2'b00);
    drain();

    // flush together with stall: bubble, counter still advances
    tick(lw(7, 1),     0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(8, 7, 0), 1, 0, 0, 1, 2'b00, 2'b00);
    tick(bub(),        0, 0, 0, 0, 2'b00, 2'b00);
    drain();

    // flush of a forwarding consumer: bubble, producer then seen from MEM
    tick(alu(5, 1, 2), 0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(6, 5, 1), 1, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(9, 5, 1), 0, 0, 0, 0, 2'b10, 2'b00);
    drain();

    // 17 load-use pairs: counter saturates at 15
    for (int k = 0; k < 17; k++) begin
      tick(lw(5, 1),     0, 0, 0, 0, 2'b00, 2'b00);
      tick(alu(6, 5, 5), 0, 0, 0, 1, 2'b00, 2'b00);
      tick(alu(6, 5, 5), 0, 0, 0, 0, 2'b10, 2'b10);
    end

    // reset mid-sequence discards the in-flight load
    tick(lw(5, 1),     0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(6, 5, 5), 0, 0, 1, 0, 2'b00, 2'b00);
    tick(alu(6, 5, 5), 0, 0, 0, 0, 2'b00, 2'b00);
    tick(alu(7, 6, 1), 0, 0, 0, 0, 2'b01, 2'b00);
    drain();

    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_select_ctrl.md
Name: fwd_select_ctrl

Overview:
- Forwarding and hazard controller for the RV32IM 5-stage pipeline.
- Tracks the destination register of every instruction in flight. Generates the 2-bit SELECT codes for the two EX-stage operand forwarding 3x1 muxes (rs1 and rs2).
- Detects load-use hazards, asserts a one-cycle stall, and counts stall cycles.
- Sits beside the ID/EX pipeline register and is clocked with it.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- ID_VALID  input  1  ID stage holds a real instruction
- ID_RS1  input  5  source register 1 of ID instruction
- ID_RS2  input  5  source register 2 of ID instruction
- ID_USES_RS1  input  1  ID instruction reads rs1
- ID_USES_RS2  input  1  ID instruction reads rs2
- ID_RD  input  5  destination register of ID instruction
- ID_REG_WRITE  input  1  ID instruction writes rd
- ID_MEM_READ  input  1  ID instruction is a load
- FLUSH  input  1  taken branch/jump; squash instruction entering EX
- HOLD  input  1  external pipeline freeze (e.g. multicycle MUL/DIV busy)
- FWD_SEL_RS1  output  2  registered SELECT for rs1 operand mux, valid during EX
- FWD_SEL_RS2  output  2  registered SELECT for rs2 operand mux, valid during EX
- STALL  output  1  combinational load-use stall: hold PC and IF/ID, bubble ID/EX
- STALL_COUNT  output  CNT_W  number of cycles STALL was effective

Behaviour:
- SELECT encoding (fixed by operand mux):
  - 00 = register file value
  - 01 = MEM-stage ALU result
  - 10 = WB-stage result
  - 11 is never driven.
- Tracking slots EX, MEM, WB each hold {valid, rd, reg_write, mem_read}. Reset clears all slots to invalid.
- Each rising edge with HOLD=0:
  - MEM<=EX, WB<=MEM.
  - EX<=ID fields if ID_VALID && !STALL && !FLUSH; otherwise EX<=bubble (all zero).
- HOLD=1: all slots, FWD_SEL_*, and STALL_COUNT freeze. HOLD has priority over FLUSH and STALL. FLUSH asserted during HOLD is ignored; the requester holds it until HOLD drops.
- "Producer P matches source s" means: P.valid && P.reg_write && P.rd!=0 && P.rd==s && the matching ID_USES_* bit is 1.
- Next-state select for each source, computed from ID inputs and current slots:
  - EX-slot match (and not load) -> 01 (producer will be in MEM next cycle).
  - Otherwise MEM-slot match -> 10 (producer will be in WB).
  - Otherwise -> 00.
  - EX-slot match has priority over MEM-slot match (youngest producer wins).
  - WB-slot matches need no forwarding: the register file is write-through.
- FWD_SEL_* are loaded with the next-state select whenever EX loads a real instruction. They are loaded with 00 whenever EX loads a bubble (stall, flush, or !ID_VALID).
- STALL = !RESET && !HOLD && ID_VALID && EX.valid && EX.mem_read && EX-slot match on either used source.
  - Exactly one stall cycle per load-use pair.
  - On the following cycle the load sits in MEM and the consumer gets select 10.
- STALL && FLUSH in the same cycle: the bubble is inserted. The counter still increments, because the stall was effective.
- STALL_COUNT:
  - Reset to 0.
  - Increments by 1 on each edge with STALL=1 and HOLD=0.
  - Saturates at all-ones; no wrap-around.
- Reset values: FWD_SEL_RS1=00, FWD_SEL_RS2=00, STALL=0, STALL_COUNT=0.
- Reset mid-operation: in-flight slots are discarded, and the first instruction after reset sees select 00.
- rd=x0 is never forwarded or stalled on, regardless of reg_write.

Test Plan:
- ADD x5 then SUB x6,x5,x1 back-to-back -> SUB in EX with FWD_SEL_RS1=01, FWD_SEL_RS2=00, STALL never 1.
- ADD x5; NOP; OR x7,x2,x5 -> OR in EX with FWD_SEL_RS2=10. Both ADD x5 and ADD x5 one apart then AND x8,x5,x5 -> both selects 01 (youngest wins).
- LW x5 then ADD x6,x5,x5 -> STALL=1 for exactly one cycle, bubble in EX with selects 00, then ADD in EX with both selects 10; STALL_COUNT 0->1.
- ADDI x0,x0,1 then ADD x1,x0,x0 -> selects 00, no stall. LW x3 followed by a consumer not using x3 -> no stall.
- LW x5; consumer of x5 with HOLD=1 for 3 cycles -> STALL=0, slots and STALL_COUNT frozen. After HOLD drops: one stall cycle, then select 10. FLUSH during stall -> EX bubble, selects 00.
- Preload STALL_COUNT to near max via CNT_W=4 and 17 load-use pairs -> counter stops at 15. Assert RESET mid-sequence -> all outputs 0 on next edge.
